// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU, load/store address generation and an
// optional iterative shift-add multiplier with a decode stall.
// Build option: define EX_MUL_EN to build the multiplier. Without it, op 1010
// is treated as undefined and ex_busy is tied low.
module ex_stage (
  input  logic         clk,
  input  logic         reset,
  input  logic         over,
  input  logic [105:0] idbus,
  output logic [73:0]  exbus,
  output logic [4:0]   ex_dst,
  output logic [32:0]  ex_bypass,
  output logic         ex_busy
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OP_W  = 4;
  localparam int unsigned DST_W = 5;
  localparam int unsigned BUS_W = 1 + OP_W + DST_W + XLEN + XLEN;

  localparam logic [OP_W-1:0] OP_ADD   = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB   = 4'b0001;
  localparam logic [OP_W-1:0] OP_AND   = 4'b0010;
  localparam logic [OP_W-1:0] OP_OR    = 4'b0011;
  localparam logic [OP_W-1:0] OP_XOR   = 4'b0100;
  localparam logic [OP_W-1:0] OP_SLL   = 4'b0101;
  localparam logic [OP_W-1:0] OP_SRL   = 4'b0110;
  localparam logic [OP_W-1:0] OP_SLT   = 4'b0111;
  localparam logic [OP_W-1:0] OP_LOAD  = 4'b1000;
  localparam logic [OP_W-1:0] OP_STORE = 4'b1001;

  logic             id_valid;
  logic [OP_W-1:0]  id_op;
  logic [DST_W-1:0] id_dst;
  logic [XLEN-1:0]  id_srca;
  logic [XLEN-1:0]  id_srcb;
  logic [XLEN-1:0]  id_stval;

  assign id_valid = idbus[105];
  assign id_op    = idbus[104:101];
  assign id_dst   = idbus[100:96];
  assign id_srca  = idbus[95:64];
  assign id_srcb  = idbus[63:32];
  assign id_stval = idbus[31:0];

  logic [XLEN-1:0]  alu_res;
  logic             alu_op_ok;
  logic [BUS_W-1:0] alu_bus;
  logic [32:0]      alu_byp;
  logic [BUS_W-1:0] exbus_q;
  logic [BUS_W-1:0] exbus_d;

  // Single-cycle ALU result; undefined ops produce zero
  always_comb begin
    alu_res = '0;
    case (id_op)
      OP_ADD:   alu_res = id_srca + id_srcb;
      OP_SUB:   alu_res = id_srca - id_srcb;
      OP_AND:   alu_res = id_srca & id_srcb;
      OP_OR:    alu_res = id_srca | id_srcb;
      OP_XOR:   alu_res = id_srca ^ id_srcb;
      OP_SLL:   alu_res = id_srca << id_srcb[4:0];
      OP_SRL:   alu_res = id_srca >> id_srcb[4:0];
      OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, ($signed(id_srca) < $signed(id_srcb))};
      OP_LOAD:  alu_res = id_srca + id_srcb;
      OP_STORE: alu_res = id_srca + id_srcb;
      default:  alu_res = '0;
    endcase
  end

  assign alu_op_ok = id_valid && (id_op <= OP_STORE);
  assign alu_bus   = alu_op_ok ? {1'b1, id_op, id_dst, alu_res,
                                  (id_op == OP_STORE) ? id_stval : {XLEN{1'b0}}}
                               : {BUS_W{1'b0}};
  // Only register-writing ALU ops (op[3] = 0) are forwardable
  assign alu_byp   = (id_valid && !id_op[3]) ? {1'b1, alu_res} : 33'b0;

`ifdef EX_MUL_EN
  localparam int unsigned MUL_CYCLES = 32;
  localparam int unsigned CNT_W      = $clog2(MUL_CYCLES);
  localparam logic [OP_W-1:0] OP_MUL = 4'b1010;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  acc_q, acc_d;
  logic [XLEN-1:0]  a_q, a_d;
  logic [XLEN-1:0]  b_q, b_d;
  logic [DST_W-1:0] dst_q, dst_d;
  logic             mul_req;
  logic             mul_last;
  logic [XLEN-1:0]  acc_next;

  assign mul_req  = id_valid && (id_op == OP_MUL);
  assign mul_last = (cnt_q == CNT_W'(MUL_CYCLES - 1));
  assign acc_next = acc_q + (b_q[0] ? a_q : {XLEN{1'b0}});

  // State and multiplier registers; reset wins over the freeze
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      dst_q   <= '0;
    end else if (!over) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dst_q   <= dst_d;
    end
  end

  // Next state and one shift-add iteration per RUN cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    dst_d   = dst_q;
    case (state_q)
      S_IDLE: begin
        if (mul_req) begin
          state_d = S_RUN;
          cnt_d   = '0;
          acc_d   = '0;
          a_d     = id_srca;
          b_d     = id_srcb;
          dst_d   = id_dst;
        end
      end
      S_RUN: begin
        acc_d = acc_next;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (mul_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs; the finished product is re-encoded as ADD for forwarding downstream
  always_comb begin
    exbus_d   = '0;
    ex_busy   = 1'b0;
    ex_dst    = '0;
    ex_bypass = '0;
    case (state_q)
      S_IDLE: begin
        exbus_d   = alu_bus;
        ex_busy   = mul_req;
        ex_dst    = id_valid ? id_dst : {DST_W{1'b0}};
        ex_bypass = alu_byp;
      end
      S_RUN: begin
        ex_busy = !mul_last;
        ex_dst  = dst_q;
        if (mul_last) exbus_d = {1'b1, OP_ADD, dst_q, acc_next, {XLEN{1'b0}}};
      end
      default: ;
    endcase
  end
`else
  // Outputs without the multiplier: the stage never stalls
  always_comb begin
    exbus_d   = alu_bus;
    ex_busy   = 1'b0;
    ex_dst    = id_valid ? id_dst : {DST_W{1'b0}};
    ex_bypass = alu_byp;
  end
`endif

  // Registered result bus toward mem_stage
  always_ff @(posedge clk) begin
    if (reset)      exbus_q <= '0;
    else if (!over) exbus_q <= exbus_d;
  end

  assign exbus = exbus_q;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed and randomized ALU traffic against a
// plain-arithmetic model, plus multiplier latency, freeze and abort scenarios.
module tb_ex_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         over;
  logic [105:0] idbus;
  logic [73:0]  exbus;
  logic [4:0]   ex_dst;
  logic [32:0]  ex_bypass;
  logic         ex_busy;

  int checks = 0;
  int errors = 0;

  ex_stage dut (
    .clk      (clk),
    .reset    (reset),
    .over     (over),
    .idbus    (idbus),
    .exbus    (exbus),
    .ex_dst   (ex_dst),
    .ex_bypass(ex_bypass),
    .ex_busy  (ex_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [3:0]  op;
    logic [4:0]  d;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] st;
    logic        def;
    logic [31:0] res;
    logic [31:0] xst;
    logic        byp;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [105:0] mk(input logic v, input logic [3:0] op, input logic [4:0] d,
                                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] st);
    return {v, op, d, a, b, st};
  endfunction

  // Reference result from plain integer arithmetic
  function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint unsigned ua, ub, pw;
    longint sa, sb;
    ua = {32'b0, a};
    ub = {32'b0, b};
    pw = 64'd1 << b[4:0];
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd0:    return 32'(ua + ub);
      4'd1:    return 32'(ua + 64'h1_0000_0000 - ub);
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return 32'(ua * pw);
      4'd6:    return 32'(ua / pw);
      4'd7:    return (sa < sb) ? 32'd1 : 32'd0;
      4'd8:    return 32'(ua + ub);
      4'd9:    return 32'(ua + ub);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [73:0] ref_bus(input logic v, input logic [3:0] op, input logic [4:0] d,
                                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] st);
    if (v && op <= 4'd9) return {1'b1, op, d, ref_res(op, a, b), (op == 4'd9) ? st : 32'd0};
    return 74'd0;
  endfunction

  task automatic test_reset();
    logic [73:0] exp;
    reset = 1'b1; over = 1'b0; idbus = '0;
    step(); step();
    checks++;
    if (exbus !== 74'd0) begin errors++; $display("FAIL reset_exbus: got %h expected 0", exbus); end
    reset = 1'b0;
    #1;
    checks++;
    if (ex_busy !== 1'b0 || ex_dst !== 5'd0 || ex_bypass !== 33'd0) begin
      errors++;
      $display("FAIL reset_comb: got busy=%b dst=%h byp=%h expected 0/0/0", ex_busy, ex_dst, ex_bypass);
    end
    // Reset must win over a simultaneous freeze
    idbus = mk(1'b1, 4'd0, 5'd2, 32'd10, 32'd20, 32'd0);
    exp = {1'b1, 4'd0, 5'd2, 32'd30, 32'd0};
    step();
    checks++;
    if (exbus !== exp) begin errors++; $display("FAIL pre_reset_add: got %h expected %h", exbus, exp); end
    reset = 1'b1; over = 1'b1; idbus = '0;
    step();
    checks++;
    if (exbus !== 74'd0) begin errors++; $display("FAIL reset_over_freeze: got %h expected 0", exbus); end
    reset = 1'b0; over = 1'b0;
    step();
  endtask

  task automatic test_alu_directed();
    vec_t tbl[10];
    logic [73:0] exp_bus;
    logic [32:0] exp_byp;
    logic [4:0]  exp_dst;
    tbl[0] = '{1'b1, 4'd0, 5'd7, 32'd5,          32'd3,  32'd0,          1'b1, 32'd8,          32'd0,          1'b1};
    tbl[1] = '{1'b1, 4'd7, 5'd1, 32'hFFFFFFFF,   32'd1,  32'd0,          1'b1, 32'd1,          32'd0,          1'b1};
    tbl[2] = '{1'b1, 4'd6, 5'd2, 32'h80000000,   32'd31, 32'd0,          1'b1, 32'd1,          32'd0,          1'b1};
    tbl[3] = '{1'b1, 4'd9, 5'd0, 32'h100,        32'd4,  32'hDEADBEEF,   1'b1, 32'h104,        32'hDEADBEEF,   1'b0};
    tbl[4] = '{1'b1, 4'd1, 5'd4, 32'd3,          32'd5,  32'h1234,       1'b1, 32'hFFFFFFFE,   32'd0,          1'b1};
    tbl[5] = '{1'b1, 4'd5, 5'd5, 32'd1,          32'd31, 32'd0,          1'b1, 32'h80000000,   32'd0,          1'b1};
    tbl[6] = '{1'b1, 4'd8, 5'd6, 32'hFFFFFFFC,   32'd8,  32'hAAAA,       1'b1, 32'd4,          32'd0,          1'b0};
    tbl[7] = '{1'b1, 4'd7, 5'd8, 32'd1,          32'hFFFFFFFF, 32'd0,    1'b1, 32'd0,          32'd0,          1'b1};
    tbl[8] = '{1'b0, 4'd0, 5'd9, 32'd1,          32'd2,  32'd0,          1'b0, 32'd0,          32'd0,          1'b0};
    tbl[9] = '{1'b1, 4'd15, 5'd10, 32'd1,        32'd2,  32'd0,          1'b0, 32'd0,          32'd0,          1'b0};
    foreach (tbl[i]) begin
      idbus   = mk(tbl[i].v, tbl[i].op, tbl[i].d, tbl[i].a, tbl[i].b, tbl[i].st);
      exp_bus = tbl[i].def ? {1'b1, tbl[i].op, tbl[i].d, tbl[i].res, tbl[i].xst} : 74'd0;
      exp_byp = tbl[i].byp ? {1'b1, tbl[i].res} : 33'd0;
      exp_dst = tbl[i].v ? tbl[i].d : 5'd0;
      #1;
      checks++;
      if (ex_bypass !== exp_byp || ex_dst !== exp_dst || ex_busy !== 1'b0) begin
        errors++;
        $display("FAIL directed_comb[%0d]: got byp=%h dst=%h busy=%b expected byp=%h dst=%h busy=0",
                 i, ex_bypass, ex_dst, ex_busy, exp_byp, exp_dst);
      end
      step();
      checks++;
      if (exbus !== exp_bus) begin
        errors++;
        $display("FAIL directed_exbus[%0d]: got %h expected %h", i, exbus, exp_bus);
      end
    end
    idbus = '0;
  endtask

  task automatic test_random_alu();
    logic        v, frz;
    logic [3:0]  op;
    logic [4:0]  d;
    logic [31:0] a, b, st;
    logic [73:0] exp_bus, prev_bus;
    logic [32:0] exp_byp;
    prev_bus = '0;
    for (int i = 0; i < 300; i++) begin
      v   = ($urandom_range(0, 7) != 0);
      op  = 4'($urandom_range(0, 15));
`ifdef EX_MUL_EN
      if (op == 4'd10) op = 4'd11;
`endif
      d   = 5'($urandom);
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      st  = $urandom;
      frz = (i != 0) && ($urandom_range(0, 9) == 0);
      idbus = mk(v, op, d, a, b, st);
      over  = frz;
      exp_byp = (v && !op[3]) ? {1'b1, ref_res(op, a, b)} : 33'd0;
      exp_bus = frz ? prev_bus : ref_bus(v, op, d, a, b, st);
      #1;
      checks++;
      if (ex_bypass !== exp_byp || ex_dst !== (v ? d : 5'd0)) begin
        errors++;
        $display("FAIL random_comb[%0d] op=%0d: got byp=%h dst=%h expected byp=%h dst=%h",
                 i, op, ex_bypass, ex_dst, exp_byp, v ? d : 5'd0);
      end
      step();
      checks++;
      if (exbus !== exp_bus) begin
        errors++;
        $display("FAIL random_exbus[%0d] op=%0d frz=%b: got %h expected %h", i, op, frz, exbus, exp_bus);
      end
      prev_bus = exp_bus;
    end
    over = 1'b0;
    idbus = '0;
    step();
  endtask

`ifdef EX_MUL_EN
  task automatic test_mul();
    logic [31:0] ma[6], mb[6];
    logic [4:0]  md[6];
    int          fat[6], flen[6], lat[6];
    logic [73:0] exp_bus;
    int          busy_n, got_at;
    ma[0] = 32'd7;         mb[0] = 32'd6;      md[0] = 5'd3;  fat[0] = 0;  flen[0] = 0;
    ma[1] = 32'hFFFFFFFF;  mb[1] = 32'd2;      md[1] = 5'd9;  fat[1] = 0;  flen[1] = 0;
    ma[2] = $urandom;      mb[2] = $urandom;   md[2] = 5'd17; fat[2] = 0;  flen[2] = 0;
    ma[3] = $urandom;      mb[3] = $urandom;   md[3] = 5'd31; fat[3] = 0;  flen[3] = 0;
    ma[4] = 32'd7;         mb[4] = 32'd6;      md[4] = 5'd3;  fat[4] = 10; flen[4] = 5;
    ma[5] = 32'd12345;     mb[5] = 32'd6789;   md[5] = 5'd1;  fat[5] = 0;  flen[5] = 3;
    for (int k = 0; k < 6; k++) begin
      exp_bus = {1'b1, 4'd0, md[k], 32'({32'b0, ma[k]} * {32'b0, mb[k]}), 32'd0};
      idbus   = mk(1'b1, 4'd10, md[k], ma[k], mb[k], $urandom);
      busy_n  = 0;
      got_at  = -1;
      for (int cyc = 0; cyc < 60; cyc++) begin
        over = (flen[k] > 0) && (cyc >= fat[k]) && (cyc < fat[k] + flen[k]);
        #1;
        if (ex_busy === 1'b1) busy_n++;
        checks++;
        if (ex_dst !== md[k] || ex_bypass !== 33'd0) begin
          errors++;
          $display("FAIL mul_comb[%0d] cyc=%0d: got dst=%h byp=%h expected dst=%h byp=0",
                   k, cyc, ex_dst, ex_bypass, md[k]);
        end
        step();
        if (exbus[73] === 1'b1) begin
          got_at = cyc + 1;
          break;
        end
        checks++;
        if (exbus !== 74'd0) begin
          errors++;
          $display("FAIL mul_bubble[%0d] cyc=%0d: got %h expected 0", k, cyc, exbus);
        end
      end
      idbus = '0;
      over  = 1'b0;
      lat[k] = got_at;
      checks++;
      if (got_at != 33 + flen[k]) begin
        errors++;
        $display("FAIL mul_latency[%0d]: got %0d expected %0d", k, got_at, 33 + flen[k]);
      end
      checks++;
      if (got_at > 0 && exbus !== exp_bus) begin
        errors++;
        $display("FAIL mul_product[%0d]: got %h expected %h", k, exbus, exp_bus);
      end
      checks++;
      if (busy_n != 32 + flen[k]) begin
        errors++;
        $display("FAIL mul_busy_cycles[%0d]: got %0d expected %0d", k, busy_n, 32 + flen[k]);
      end
      #1;
      checks++;
      if (ex_busy !== 1'b0 || ex_dst !== 5'd0) begin
        errors++;
        $display("FAIL mul_after[%0d]: got busy=%b dst=%h expected 0/0", k, ex_busy, ex_dst);
      end
      step();
      checks++;
      if (exbus !== 74'd0) begin
        errors++;
        $display("FAIL mul_tail[%0d]: got %h expected 0", k, exbus);
      end
    end
    checks++;
    if (lat[4] - lat[0] != 5) begin
      errors++;
      $display("FAIL mul_freeze_delay: got %0d expected 5", lat[4] - lat[0]);
    end
  endtask

  task automatic test_reset_abort();
    logic seen;
    idbus = mk(1'b1, 4'd10, 5'd3, 32'd7, 32'd6, 32'd0);
    over  = 1'b0;
    for (int i = 0; i < 11; i++) step();
    reset = 1'b1;
    step();
    checks++;
    if (exbus !== 74'd0) begin errors++; $display("FAIL abort_exbus: got %h expected 0", exbus); end
    reset = 1'b0;
    idbus = '0;
    #1;
    checks++;
    if (ex_busy !== 1'b0 || ex_dst !== 5'd0) begin
      errors++;
      $display("FAIL abort_comb: got busy=%b dst=%h expected 0/0", ex_busy, ex_dst);
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (exbus !== 74'd0 || ex_busy !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_product: got activity=%b expected 0", seen); end
  endtask
`else
  task automatic test_mul();
    idbus = mk(1'b1, 4'd10, 5'd3, 32'd7, 32'd6, 32'd0);
    for (int f = 0; f < 2; f++) begin
      over = (f == 1);
      #1;
      checks++;
      if (ex_busy !== 1'b0 || ex_bypass !== 33'd0 || ex_dst !== 5'd3) begin
        errors++;
        $display("FAIL nomul_comb[%0d]: got busy=%b byp=%h dst=%h expected 0/0/3", f, ex_busy, ex_bypass, ex_dst);
      end
      over = 1'b0;
      step();
      checks++;
      if (exbus !== 74'd0) begin errors++; $display("FAIL nomul_exbus[%0d]: got %h expected 0", f, exbus); end
    end
    idbus = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_alu_directed();
    test_random_alu();
    test_mul();
`ifdef EX_MUL_EN
    test_reset_abort();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
